// File: rtl/ahb_decoder_dp_if.sv
// Bus-side signal bundle for the AHB address decoder of one master port.
// The slave modport is the decoder's view; master is the driver's view.
interface ahb_decoder_dp_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int SLV_NUM       = 4,
  parameter int ERR_CNT_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]    haddr;
  logic [1:0]               htrans;
  logic                     hready;
  logic                     hremap;
  logic                     err_clr;
  logic [SLV_NUM-1:0]       hsel;
  logic [SLV_NUM-1:0]       hsel_dp;
  logic                     dflt_sel_dp;
  logic                     dflt_hready;
  logic                     dflt_hresp;
  logic [ERR_CNT_WIDTH-1:0] err_count;
  logic [ADDR_WIDTH-1:0]    err_addr;

  modport slave (
    input  haddr, htrans, hready, hremap, err_clr,
    output hsel, hsel_dp, dflt_sel_dp, dflt_hready, dflt_hresp, err_count, err_addr
  );

  modport master (
    output haddr, htrans, hready, hremap, err_clr,
    input  hsel, hsel_dp, dflt_sel_dp, dflt_hready, dflt_hresp, err_count, err_addr
  );
endinterface

// File: rtl/ahb_decoder_dp.sv
// AHB address decoder: priority region match with boot remap swap,
// data-phase select register, and an integrated default slave that
// answers unmapped transfers with the two-cycle ERROR response and
// keeps a saturating error count plus the last errored address.
module ahb_decoder_dp #(
  parameter int ADDR_WIDTH    = 32,
  parameter int SLV_NUM       = 4,
  parameter logic [SLV_NUM*ADDR_WIDTH-1:0] LOW_ADDR =
    {32'h4000_0000, 32'h2000_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [SLV_NUM*ADDR_WIDTH-1:0] HIGH_ADDR =
    {32'h4FFF_FFFF, 32'h2000_0FFF, 32'h0001_FFFF, 32'h0000_FFFF},
  parameter int REMAP_SLV     = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic             hclk,
  input  logic             hreset,
  ahb_decoder_dp_if.slave  bus
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dflt_state_e;

  logic [SLV_NUM-1:0]       match;
  logic [SLV_NUM-1:0]       region_hit;
  logic [SLV_NUM-1:0]       slv_hit;
  logic [SLV_NUM-1:0]       hsel;
  logic                     any_match;
  logic                     unmapped;
  logic                     err_entry;

  dflt_state_e              state_d, state_q;
  logic [SLV_NUM-1:0]       hsel_dp_d, hsel_dp_q;
  logic                     dflt_sel_dp_d, dflt_sel_dp_q;
  logic [ERR_CNT_WIDTH-1:0] err_count_d, err_count_q;
  logic [ADDR_WIDTH-1:0]    err_addr_d, err_addr_q;
  logic                     dflt_hready;
  logic                     dflt_hresp;

  // Inclusive, full-width unsigned bounds check for every region.
  for (genvar i = 0; i < SLV_NUM; i++) begin : g_match
    assign match[i] = (bus.haddr >= LOW_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                      (bus.haddr <= HIGH_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]);
  end

  assign any_match = |match;

  // Resolve overlaps (lowest region wins), then apply the boot remap swap.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    region_hit = '0;
    for (int i = SLV_NUM - 1; i >= 0; i--) begin
      if (match[i]) begin
        region_hit    = '0;
        region_hit[i] = 1'b1;
      end
    end
    slv_hit = region_hit;
    if (bus.hremap) begin
      slv_hit[0]         = region_hit[REMAP_SLV];
      slv_hit[REMAP_SLV] = region_hit[0];
    end
  end

  assign hsel      = (bus.htrans == HTRANS_IDLE) ? '0 : slv_hit;
  assign unmapped  = bus.htrans[1] && !any_match;
  assign err_entry = bus.hready && unmapped && (state_q != D_ERR1);

  // Data-phase select and error bookkeeping, advanced only when the address phase is sampled.
  always_comb begin
    hsel_dp_d     = hsel_dp_q;
    dflt_sel_dp_d = dflt_sel_dp_q;
    err_addr_d    = err_addr_q;
    err_count_d   = err_count_q;
    if (bus.hready) begin
      hsel_dp_d     = hsel;
      dflt_sel_dp_d = unmapped || ((bus.htrans == HTRANS_BUSY) && !any_match);
    end
    if (err_entry) begin
      err_addr_d = bus.haddr;
    end
    if (bus.err_clr) begin
      err_count_d = err_entry ? ERR_CNT_WIDTH'(1) : '0;
    end else if (err_entry && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
    end
  end

  // Default slave next state and response outputs.
  always_comb begin
    state_d     = state_q;
    dflt_hready = 1'b1;
    dflt_hresp  = 1'b0;
    unique case (state_q)
      D_IDLE: begin
        if (err_entry) state_d = D_ERR1;
      end
      D_ERR1: begin
        dflt_hready = 1'b0;
        dflt_hresp  = 1'b1;
        state_d     = D_ERR2;
      end
      D_ERR2: begin
        dflt_hresp = 1'b1;
        state_d    = err_entry ? D_ERR1 : D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q       <= D_IDLE;
      hsel_dp_q     <= '0;
      dflt_sel_dp_q <= 1'b0;
      err_count_q   <= '0;
      err_addr_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q       <= state_d;
      hsel_dp_q     <= hsel_dp_d;
      dflt_sel_dp_q <= dflt_sel_dp_d;
      err_count_q   <= err_count_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign bus.hsel        = hsel;
  assign bus.hsel_dp     = hsel_dp_q;
  assign bus.dflt_sel_dp = dflt_sel_dp_q;
  assign bus.dflt_hready = dflt_hready;
  assign bus.dflt_hresp  = dflt_hresp;
  assign bus.err_count   = err_count_q;
  assign bus.err_addr    = err_addr_q;

endmodule

// File: tb/tb_ahb_decoder_dp.sv
// Self-checking bench for ahb_decoder_dp: directed vector table, hand-written
// error/reset sequences and random traffic against a behavioural model.
module tb_ahb_decoder_dp;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [31:0] LO [4] = '{32'h0000_0000, 32'h0001_0000, 32'h2000_0000, 32'h4000_0000};
  localparam logic [31:0] HI [4] = '{32'h0000_FFFF, 32'h0001_FFFF, 32'h2000_0FFF, 32'h4FFF_FFFF};

  logic hclk;
  logic hreset;

  ahb_decoder_dp_if #(.ADDR_WIDTH(32), .SLV_NUM(4), .ERR_CNT_WIDTH(8)) u_if ();
  ahb_decoder_dp_if #(.ADDR_WIDTH(32), .SLV_NUM(4), .ERR_CNT_WIDTH(2)) u_if2 ();

  ahb_decoder_dp #(.ERR_CNT_WIDTH(8)) dut     (.hclk(hclk), .hreset(hreset), .bus(u_if.slave));
  ahb_decoder_dp #(.ERR_CNT_WIDTH(2)) dut_sat (.hclk(hclk), .hreset(hreset), .bus(u_if2.slave));

  assign u_if2.haddr   = u_if.haddr;
  assign u_if2.htrans  = u_if.htrans;
  assign u_if2.hready  = u_if.hready;
  assign u_if2.hremap  = u_if.hremap;
  assign u_if2.err_clr = u_if.err_clr;

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [3:0]  m_hsel_dp;
  logic        m_dflt_sel;
  int          m_err_left;   // error response beats still to come: 2 = first beat, 1 = second
  int          m_cnt, m_cnt2;
  logic [31:0] m_err_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    for (int i = 0; i < 4; i++) if (a >= LO[i] && a <= HI[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] ref_hsel(input logic [31:0] a, input logic [1:0] t, input logic rm);
    int r;
    r = region_of(a);
    if (t == IDLE || r < 0) return 4'b0000;
    if (rm && r == 0) r = 1;
    else if (rm && r == 1) r = 0;
    return 4'b0001 << r;
  endfunction

  task automatic model_reset();
    m_hsel_dp  = '0;
    m_dflt_sel = 1'b0;
    m_err_left = 0;
    m_cnt      = 0;
    m_cnt2     = 0;
    m_err_addr = '0;
  endtask

  // Drive one address phase and check the combinational select.
  task automatic apply(input logic [31:0] a, input logic [1:0] t, input logic rdy,
                       input logic rm, input logic clr);
    u_if.haddr   = a;
    u_if.htrans  = t;
    u_if.hready  = rdy;
    u_if.hremap  = rm;
    u_if.err_clr = clr;
    #1;
    check("hsel", u_if.hsel, ref_hsel(a, t, rm));
  endtask

  // Advance one clock, update the model, check all registered outputs.
  task automatic tick();
    logic [3:0] hs;
    logic       mapped, unm, start_err;
    hs        = ref_hsel(u_if.haddr, u_if.htrans, u_if.hremap);
    mapped    = region_of(u_if.haddr) >= 0;
    unm       = u_if.htrans[1] && !mapped;
    start_err = u_if.hready && unm && (m_err_left != 2);
    @(posedge hclk);
    if (u_if.hready) begin
      m_hsel_dp  = hs;
      m_dflt_sel = unm || (u_if.htrans == BUSY && !mapped);
    end
    m_err_left = start_err ? 2 : (m_err_left == 2 ? 1 : 0);
    if (u_if.err_clr) begin
      m_cnt  = start_err ? 1 : 0;
      m_cnt2 = start_err ? 1 : 0;
    end else if (start_err) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (start_err) m_err_addr = u_if.haddr;
    #1;
    check("hsel_dp",     u_if.hsel_dp,     m_hsel_dp);
    check("dflt_sel_dp", u_if.dflt_sel_dp, m_dflt_sel);
    check("dflt_hready", u_if.dflt_hready, m_err_left != 2);
    check("dflt_hresp",  u_if.dflt_hresp,  m_err_left != 0);
    check("err_count",   u_if.err_count,   m_cnt);
    check("err_addr",    u_if.err_addr,    m_err_addr);
    check("err_count_w2", u_if2.err_count, m_cnt2);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        remap;
    logic [3:0]  exp_hsel;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{32'h0001_0004, NONSEQ, 1'b0, 4'b0010};
    vecs[1]  = '{32'h2000_0FFF, NONSEQ, 1'b0, 4'b0100};
    vecs[2]  = '{32'h2000_1000, NONSEQ, 1'b0, 4'b0000};
    vecs[3]  = '{32'h0000_0010, NONSEQ, 1'b1, 4'b0010};
    vecs[4]  = '{32'h0001_0010, SEQ,    1'b1, 4'b0001};
    vecs[5]  = '{32'h0000_0010, NONSEQ, 1'b0, 4'b0001};
    vecs[6]  = '{32'h0001_0010, SEQ,    1'b0, 4'b0010};
    vecs[7]  = '{32'h4000_0000, NONSEQ, 1'b0, 4'b1000};
    vecs[8]  = '{32'h4FFF_FFFF, SEQ,    1'b0, 4'b1000};
    vecs[9]  = '{32'h5000_0000, NONSEQ, 1'b0, 4'b0000};
    vecs[10] = '{32'h0000_0000, IDLE,   1'b0, 4'b0000};
    vecs[11] = '{32'h0000_FFFF, BUSY,   1'b0, 4'b0001};
    vecs[12] = '{32'h1FFF_FFFF, NONSEQ, 1'b0, 4'b0000};
    vecs[13] = '{32'h4000_0004, NONSEQ, 1'b1, 4'b1000};

    // Reset state
    hreset = 1'b1;
    u_if.haddr = '0; u_if.htrans = IDLE; u_if.hready = 1'b1; u_if.hremap = 1'b0; u_if.err_clr = 1'b0;
    model_reset();
    #12;
    check("rst_hsel_dp",     u_if.hsel_dp, 4'b0000);
    check("rst_dflt_sel_dp", u_if.dflt_sel_dp, 1'b0);
    check("rst_dflt_hready", u_if.dflt_hready, 1'b1);
    check("rst_dflt_hresp",  u_if.dflt_hresp, 1'b0);
    check("rst_err_count",   u_if.err_count, 8'd0);
    check("rst_err_addr",    u_if.err_addr, 32'd0);
    #8;
    hreset = 1'b0;

    // Directed decode table
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].addr, vecs[i].trans, 1'b1, vecs[i].remap, 1'b0);
      check("tbl_hsel", u_if.hsel, vecs[i].exp_hsel);
      tick();
    end
    apply(32'h0, IDLE, 1'b1, 1'b0, 1'b1); tick();
    apply(32'h0, IDLE, 1'b1, 1'b0, 1'b0); tick();

    // Latency on a mapped transfer
    apply(32'h0001_0004, NONSEQ, 1'b1, 1'b0, 1'b0); tick();
    check("lat_hsel_dp", u_if.hsel_dp, 4'b0010);
    check("lat_hready",  u_if.dflt_hready, 1'b1);
    check("lat_hresp",   u_if.dflt_hresp, 1'b0);

    // Single error just past a region top
    apply(32'h2000_1000, NONSEQ, 1'b1, 1'b0, 1'b0); tick();
    check("err1_hready", u_if.dflt_hready, 1'b0);
    check("err1_hresp",  u_if.dflt_hresp, 1'b1);
    apply(32'h0, IDLE, 1'b0, 1'b0, 1'b0); tick();
    check("err2_hready", u_if.dflt_hready, 1'b1);
    check("err2_hresp",  u_if.dflt_hresp, 1'b1);
    check("err_cnt_1",   u_if.err_count, 8'd1);
    check("err_addr_1",  u_if.err_addr, 32'h2000_1000);
    apply(32'h0, IDLE, 1'b1, 1'b0, 1'b1); tick();
    check("idle_hresp",  u_if.dflt_hresp, 1'b0);

    // Back-to-back errors, second presented in the second error beat
    apply(32'h8000_0000, NONSEQ, 1'b1, 1'b0, 1'b0); tick();
    check("b2b_s1", {u_if.dflt_hready, u_if.dflt_hresp}, 2'b01);
    apply(32'h0, IDLE, 1'b0, 1'b0, 1'b0); tick();
    check("b2b_s2", {u_if.dflt_hready, u_if.dflt_hresp}, 2'b11);
    apply(32'h9000_0000, SEQ, 1'b1, 1'b0, 1'b0); tick();
    check("b2b_s3", {u_if.dflt_hready, u_if.dflt_hresp}, 2'b01);
    apply(32'h0, IDLE, 1'b0, 1'b0, 1'b0); tick();
    check("b2b_s4", {u_if.dflt_hready, u_if.dflt_hresp}, 2'b11);
    apply(32'h0, IDLE, 1'b1, 1'b0, 1'b0); tick();
    check("b2b_s5", {u_if.dflt_hready, u_if.dflt_hresp}, 2'b10);
    check("b2b_cnt",  u_if.err_count, 8'd2);
    check("b2b_addr", u_if.err_addr, 32'h9000_0000);
    apply(32'h8000_0000, BUSY, 1'b1, 1'b0, 1'b0); tick();
    check("busy_hresp",    u_if.dflt_hresp, 1'b0);
    check("busy_dflt_sel", u_if.dflt_sel_dp, 1'b1);
    check("busy_cnt",      u_if.err_count, 8'd2);

    // Saturation of both counter widths, then clear coinciding with an entry
    apply(32'h0, IDLE, 1'b1, 1'b0, 1'b1); tick();
    for (int i = 0; i < 260; i++) begin
      apply(32'hF000_0000 + 32'(i), NONSEQ, 1'b1, 1'b0, 1'b0); tick();
      apply(32'h0, IDLE, 1'b0, 1'b0, 1'b0); tick();
      if (i == 4) check("sat_w2_5", u_if2.err_count, 2'd3);
    end
    check("sat_w8", u_if.err_count, 8'd255);
    apply(32'hE000_0000, NONSEQ, 1'b1, 1'b0, 1'b1); tick();
    check("clr_inc_w8", u_if.err_count, 8'd1);
    check("clr_inc_w2", u_if2.err_count, 2'd1);

    // Asynchronous reset in the first error beat
    apply(32'h0, IDLE, 1'b0, 1'b0, 1'b0); tick();
    apply(32'h0, IDLE, 1'b1, 1'b0, 1'b0); tick();
    apply(32'h0001_0000, NONSEQ, 1'b1, 1'b0, 1'b0); tick();
    apply(32'hA000_0000, NONSEQ, 1'b1, 1'b0, 1'b0); tick();
    check("pre_rst_hready", u_if.dflt_hready, 1'b0);
    u_if.hready = 1'b0;
    #2 hreset = 1'b1;
    #1;
    check("arst_hready",  u_if.dflt_hready, 1'b1);
    check("arst_hresp",   u_if.dflt_hresp, 1'b0);
    check("arst_hsel_dp", u_if.hsel_dp, 4'b0000);
    check("arst_cnt",     u_if.err_count, 8'd0);
    check("arst_addr",    u_if.err_addr, 32'd0);
    #1 hreset = 1'b0;
    model_reset();

    // hready low holds the data-phase select
    apply(32'h0001_0004, NONSEQ, 1'b1, 1'b0, 1'b0); tick();
    apply(32'h0, IDLE, 1'b0, 1'b0, 1'b0); tick();
    check("hold_hsel_dp", u_if.hsel_dp, 4'b0010);
    apply(32'h0, IDLE, 1'b1, 1'b0, 1'b0); tick();

    // Random traffic against the model
    begin
      logic        rm;
      logic [31:0] edges [8];
      rm = 1'b0;
      edges = '{32'h0000_0000, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_FFFF,
                 32'h2000_0000, 32'h2000_0FFF, 32'h4000_0000, 32'h4FFF_FFFF};
      for (int i = 0; i < 3000; i++) begin
        logic [31:0] a;
        logic [1:0]  t;
        logic        rdy;
        t = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0: a = edges[$urandom_range(0, 7)];
          1: a = edges[$urandom_range(0, 7)] + 32'($urandom_range(0, 2)) - 32'd1;
          default: a = $urandom;
        endcase
        rdy = (m_err_left == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (t == IDLE && $urandom_range(0, 3) == 0) rm = ~rm;
        apply(a, t, rdy, rm, $urandom_range(0, 40) == 0);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
